execute_muldiv_sequencer: RTL and testbench

//  Multi-cycle multiply/divide controller beside the execute-stage ALU. Accepts one op from
//  the ID/EX boundary and iterates a one-bit-per-cycle shift-add / restoring-divide datapath.

---
 rtl/execute_muldiv_sequencer_pkg.sv | 28 ++
 rtl/execute_muldiv_sequencer_step.sv | 35 +++
 rtl/execute_muldiv_sequencer.sv | 151 +++++++++++++++
 tb/tb_execute_muldiv_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_muldiv_sequencer_pkg.sv
// Shared op codes, FSM encodings and op-decode helpers for the execute-stage
// multiply/divide sequencer.
package execute_muldiv_sequencer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULU = 2'b01,
        OP_DIV  = 2'b10,
        OP_DIVU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/execute_muldiv_sequencer_step.sv
// One combinational iteration of the shared datapath: a shift-add multiply
// step or a restoring-divide step on a {high, low} double-width accumulator.
module execute_muldiv_sequencer_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH-1:0] acc_in,
    input  logic [DATA_WIDTH-1:0]   operand_in,
    input  logic                    is_div_in,
    output logic [2*DATA_WIDTH-1:0] acc_out
);

    logic [DATA_WIDTH:0] mul_sum;
    logic [DATA_WIDTH:0] div_rem;
    logic [DATA_WIDTH:0] div_diff;

    always_comb begin
        // Multiply: low half holds the remaining multiplier bits, LSB first.
        mul_sum  = {1'b0, acc_in[2*DATA_WIDTH-1:DATA_WIDTH]}
                 + (acc_in[0] ? {1'b0, operand_in} : '0);
        // Divide: partial remainder after shifting in the next dividend bit.
        div_rem  = acc_in[2*DATA_WIDTH-1:DATA_WIDTH-1];
        div_diff = div_rem - {1'b0, operand_in};
        acc_out  = '0;
        if (is_div_in) begin
            if (!div_diff[DATA_WIDTH]) begin
                acc_out = {div_diff[DATA_WIDTH-1:0], acc_in[DATA_WIDTH-2:0], 1'b1};
            end else begin
                acc_out = {div_rem[DATA_WIDTH-1:0], acc_in[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_out = {mul_sum, acc_in[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/execute_muldiv_sequencer.sv
// Multi-cycle MUL/MULU/DIV/DIVU sequencer beside the EX-stage ALU: stalls the
// front of the pipe while iterating, then strobes the result for one cycle.
module execute_muldiv_sequencer
    import execute_muldiv_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_in,
    input  logic                      start_in,
    input  logic [1:0]                op_in,
    input  logic [DATA_WIDTH-1:0]     operand_a_in,
    input  logic [DATA_WIDTH-1:0]     operand_b_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
    output logic                      stall_out,
    output logic                      busy_out,
    output logic                      done_out,
    output logic [DATA_WIDTH-1:0]     result_out,
    output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
    output logic                      div_by_zero_out
);

    state_e                    state_q, state_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [2*DATA_WIDTH-1:0]   acc_q, acc_d;
    logic [DATA_WIDTH-1:0]     operand_q, operand_d;
    logic                      is_div_q, is_div_d;
    logic                      sign_fix_q, sign_fix_d;
    logic [REG_ADDR_WIDTH-1:0] dest_q, dest_d;
    logic [DATA_WIDTH-1:0]     result_q, result_d;
    logic [REG_ADDR_WIDTH-1:0] addr_out_q, addr_out_d;
    logic                      dbz_q, dbz_d;

    op_e                       op_dec;
    logic                      op_signed;
    logic                      op_div;
    logic [DATA_WIDTH-1:0]     a_mag;
    logic [DATA_WIDTH-1:0]     b_mag;
    logic [2*DATA_WIDTH-1:0]   step_acc;
    logic [DATA_WIDTH-1:0]     step_lo;

    execute_muldiv_sequencer_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .acc_in     (acc_q),
        .operand_in (operand_q),
        .is_div_in  (is_div_q),
        .acc_out    (step_acc)
    );

    assign step_lo = step_acc[DATA_WIDTH-1:0];

    always_comb begin
        op_dec    = op_e'(op_in);
        op_signed = op_is_signed(op_dec);
        op_div    = op_is_div(op_dec);
        a_mag     = (op_signed && operand_a_in[DATA_WIDTH-1]) ? -operand_a_in : operand_a_in;
        b_mag     = (op_signed && operand_b_in[DATA_WIDTH-1]) ? -operand_b_in : operand_b_in;

        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        operand_d  = operand_q;
        is_div_d   = is_div_q;
        sign_fix_d = sign_fix_q;
        dest_d     = dest_q;
        result_d   = result_q;
        addr_out_d = addr_out_q;
        dbz_d      = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (start_in && !flush_in) begin
                    cnt_d      = CNT_WIDTH'(DATA_WIDTH);
                    is_div_d   = op_div;
                    sign_fix_d = op_signed && (operand_a_in[DATA_WIDTH-1] ^ operand_b_in[DATA_WIDTH-1]);
                    dest_d     = reg_wr_addr_in;
                    // Dividend / multiplier sits in the low half; the other operand stays fixed.
                    acc_d      = {{DATA_WIDTH{1'b0}}, op_div ? a_mag : b_mag};
                    operand_d  = op_div ? b_mag : a_mag;
                    if (op_div && (operand_b_in == '0)) begin
                        state_d    = ST_DONE;
                        result_d   = '1;
                        dbz_d      = 1'b1;
                        addr_out_d = reg_wr_addr_in;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (flush_in) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        state_d    = ST_DONE;
                        result_d   = sign_fix_q ? -step_lo : step_lo;
                        dbz_d      = 1'b0;
                        addr_out_d = dest_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            operand_q  <= '0;
            is_div_q   <= 1'b0;
            sign_fix_q <= 1'b0;
            dest_q     <= '0;
            result_q   <= '0;
            addr_out_q <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            operand_q  <= operand_d;
            is_div_q   <= is_div_d;
            sign_fix_q <= sign_fix_d;
            dest_q     <= dest_d;
            result_q   <= result_d;
            addr_out_q <= addr_out_d;
            dbz_q      <= dbz_d;
        end
    end

    // Stall drops in DONE so the issuing instruction advances with its result.
    assign stall_out       = !flush_in && (((state_q == ST_IDLE) && start_in) || (state_q == ST_CALC));
    assign busy_out        = (state_q != ST_IDLE);
    assign done_out        = (state_q == ST_DONE) && !flush_in;
    assign result_out      = result_q;
    assign reg_wr_addr_out = addr_out_q;
    assign div_by_zero_out = dbz_q;

endmodule

// File: tb/tb_execute_muldiv_sequencer.sv
// Bench for execute_muldiv_sequencer: table of ops plus random ops checked
// through a result scoreboard, and hand-written flush/reset/re-issue sequences.
module tb_execute_muldiv_sequencer;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_in;
    logic          start_in;
    logic [1:0]    op_in;
    logic [DW-1:0] operand_a_in;
    logic [DW-1:0] operand_b_in;
    logic [AW-1:0] reg_wr_addr_in;
    logic          stall_out;
    logic          busy_out;
    logic          done_out;
    logic [DW-1:0] result_out;
    logic [AW-1:0] reg_wr_addr_out;
    logic          div_by_zero_out;

    execute_muldiv_sequencer #(
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (AW),
        .CNT_WIDTH      (6)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_in        (flush_in),
        .start_in        (start_in),
        .op_in           (op_in),
        .operand_a_in    (operand_a_in),
        .operand_b_in    (operand_b_in),
        .reg_wr_addr_in  (reg_wr_addr_in),
        .stall_out       (stall_out),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .result_out      (result_out),
        .reg_wr_addr_out (reg_wr_addr_out),
        .div_by_zero_out (div_by_zero_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] addr;
        logic [DW-1:0] res;
        logic          dbz;
    } vec_t;

    typedef struct {
        logic [DW-1:0] res;
        logic          dbz;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[14];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (op)
            2'b00, 2'b01: r = a * b;
            2'b10: begin
                if (b == '0) r = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = $signed(a) / $signed(b);
            end
            default: r = (b == '0) ? '1 : a / b;
        endcase
        return r;
    endfunction

    // Scoreboard: every result strobe must match the oldest outstanding op.
    always @(negedge clk) begin
        if (done_out) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'(done_out), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", result_out, e.res);
                chk("div_by_zero", 32'(div_by_zero_out), 32'(e.dbz));
                chk("reg_wr_addr", 32'(reg_wr_addr_out), 32'(e.addr));
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [AW-1:0] addr, input logic [DW-1:0] er, input logic ed);
        int  lat;
        bit  seen;
        bit  stall_ok;
        exp_t e;
        lat = (op[1] && b == '0) ? 1 : DW + 1;
        @(posedge clk); #2;
        start_in = 1'b1; op_in = op; operand_a_in = a; operand_b_in = b; reg_wr_addr_in = addr;
        e.res = er; e.dbz = ed; e.addr = addr;
        sb_q.push_back(e);
        @(negedge clk);
        chk("stall_at_issue", 32'(stall_out), 32'd1);
        @(posedge clk); #2;
        start_in = 1'b0; op_in = 2'($urandom); operand_a_in = $urandom; operand_b_in = $urandom;
        reg_wr_addr_in = AW'($urandom);
        seen = 0; stall_ok = 1;
        for (int k = 1; k <= lat + 3 && !seen; k++) begin
            @(negedge clk);
            if (stall_out !== (k < lat)) stall_ok = 0;
            if (done_out) begin
                seen = 1;
                chk("latency", 32'(k), 32'(lat));
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("stall_profile", 32'(stall_ok), 32'd1);
        @(negedge clk);
        chk("busy_after_done", 32'(busy_out), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        rst = 1'b1; flush_in = 1'b0; start_in = 1'b0; op_in = 2'b00;
        operand_a_in = '0; operand_b_in = '0; reg_wr_addr_in = '0;

        vecs[0]  = '{2'b01, 32'd7,          32'd6,          5'd1,  32'd42,         1'b0};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFD,  32'd5,          5'd2,  32'hFFFF_FFF1,  1'b0};
        vecs[2]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd3,  32'h8000_0000,  1'b0};
        vecs[3]  = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4,  32'd1,          1'b0};
        vecs[4]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          5'd5,  32'hFFFF_FFFD,  1'b0};
        vecs[5]  = '{2'b11, 32'hFFFF_FFFF,  32'h10,         5'd6,  32'h0FFF_FFFF,  1'b0};
        vecs[6]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'h8000_0000,  1'b0};
        vecs[7]  = '{2'b10, 32'd5,          32'd0,          5'd8,  32'hFFFF_FFFF,  1'b1};
        vecs[8]  = '{2'b11, 32'd100,        32'd7,          5'd9,  32'd14,         1'b0};
        vecs[9]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  5'd10, 32'hFFFF_FFFD,  1'b0};
        vecs[10] = '{2'b10, 32'hFFFF_FFF8,  32'd0,          5'd11, 32'hFFFF_FFFF,  1'b1};
        vecs[11] = '{2'b01, 32'h1234_5678,  32'h10,         5'd12, 32'h2345_6780,  1'b0};
        vecs[12] = '{2'b10, 32'hFFFF_FFF7,  32'hFFFF_FFFD,  5'd13, 32'd3,          1'b0};
        vecs[13] = '{2'b11, 32'd3,          32'd0,          5'd31, 32'hFFFF_FFFF,  1'b1};

        #1;
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        chk("rst_result", result_out, 32'd0);
        chk("rst_addr", 32'(reg_wr_addr_out), 32'd0);
        chk("rst_dbz", 32'(div_by_zero_out), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].addr, vecs[i].res, vecs[i].dbz);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]    op;
            logic [DW-1:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 31);
            if (i == 3) b = '0;
            run_op(op, a, b, AW'(i + 16), model(op, a, b), op[1] && (b == '0));
        end

        // Flush mid-multiply: aborts without a strobe and keeps the old result.
        run_op(2'b01, 32'd7, 32'd6, 5'd5, 32'd42, 1'b0);
        @(posedge clk); #2;
        start_in = 1'b1; op_in = 2'b00; operand_a_in = 32'd9; operand_b_in = 32'd9;
        reg_wr_addr_in = 5'd20;
        @(posedge clk); #2;
        start_in = 1'b0;
        repeat (9) @(posedge clk);
        #2 flush_in = 1'b1;
        @(negedge clk);
        chk("flush_stall", 32'(stall_out), 32'd0);
        chk("flush_done", 32'(done_out), 32'd0);
        chk("flush_busy_before", 32'(busy_out), 32'd1);
        @(posedge clk); #2;
        flush_in = 1'b0;
        @(negedge clk);
        chk("flush_idle", 32'(busy_out), 32'd0);
        chk("flush_keep_result", result_out, 32'd42);
        chk("flush_keep_addr", 32'(reg_wr_addr_out), 32'd5);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd21, 32'hFFFF_FFFD, 1'b0);

        // start_in held through DONE is only re-accepted in the following IDLE.
        @(posedge clk); #2;
        start_in = 1'b1; op_in = 2'b11; operand_a_in = 32'd5; operand_b_in = 32'd0;
        reg_wr_addr_in = 5'd9;
        sb_q.push_back('{32'hFFFF_FFFF, 1'b1, 5'd9});
        sb_q.push_back('{32'hFFFF_FFFF, 1'b1, 5'd9});
        @(negedge clk);
        chk("hold_stall_n", 32'(stall_out), 32'd1);
        @(negedge clk);
        chk("hold_done_n1", 32'(done_out), 32'd1);
        chk("hold_stall_n1", 32'(stall_out), 32'd0);
        @(negedge clk);
        chk("hold_done_n2", 32'(done_out), 32'd0);
        chk("hold_busy_n2", 32'(busy_out), 32'd0);
        chk("hold_stall_n2", 32'(stall_out), 32'd1);
        @(negedge clk);
        chk("hold_done_n3", 32'(done_out), 32'd1);
        @(posedge clk); #2;
        start_in = 1'b0;

        // Asynchronous reset in the middle of a DIVU.
        @(posedge clk); #2;
        start_in = 1'b1; op_in = 2'b11; operand_a_in = 32'd100; operand_b_in = 32'd7;
        reg_wr_addr_in = 5'd3;
        @(posedge clk); #2;
        start_in = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy_out), 32'd0);
        chk("midrst_stall", 32'(stall_out), 32'd0);
        chk("midrst_done", 32'(done_out), 32'd0);
        chk("midrst_result", result_out, 32'd0);
        chk("midrst_addr", 32'(reg_wr_addr_out), 32'd0);
        chk("midrst_dbz", 32'(div_by_zero_out), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_out) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);
        run_op(2'b01, 32'd7, 32'd6, 5'd30, 32'd42, 1'b0);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
